hero_mov_ctrl: RTL and testbench

Parametrised hero-movement controller for the hero game.
- Turns keypad presses into timed hero actions: fly, jump or crouch.
- Each action is held for a fixed number of cycles, then followed by a cooldown.
- Only acts while the top-level state machine is in the game state.
- Per-hero ability mask gates flying.
- Sits between the keypad decoder / top FSM and the hero sprite/collision logic.

---
 rtl/hero_mov_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hero_mov_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hero_mov_ctrl.sv
// Hero movement controller: keypad presses become timed fly/jump/crouch actions with cooldown.
// Optional one-deep press buffer when MOV_BUFFER_EN is defined.
module hero_mov_ctrl #(
    parameter logic [3:0]  STATE_JUEGO     = 4'd3,
    parameter logic [4:0]  KEY_VOLAR       = 5'd2,
    parameter logic [4:0]  KEY_SALTAR      = 5'd6,
    parameter logic [4:0]  KEY_AGACHAR     = 5'd8,
    parameter int unsigned ACT_CYCLES      = 16,
    parameter int unsigned COOLDOWN_CYCLES = 8,
    parameter int unsigned CNT_W           = 16,
    parameter logic [7:0]  HERO_FLY_MASK   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] presente,
    input  logic       keypad_pressed,
    input  logic [4:0] key,
    input  logic [2:0] heroe_seleccionado,
    output logic [1:0] mov,
    output logic       busy,
    output logic       accepted,
    output logic [2:0] heroe_act
);

    typedef enum logic [1:0] {StIdle, StAction, StCooldown} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         mov_q, mov_d;
    logic               busy_q, busy_d;
    logic               accepted_q, accepted_d;
    logic [2:0]         heroe_act_q, heroe_act_d;
    logic               kp_q;

    logic               press;
    logic               valid;
    logic               done;
    logic [1:0]         code;

`ifdef MOV_BUFFER_EN
    logic               buf_full_q, buf_full_d;
    logic [1:0]         buf_code_q, buf_code_d;
    logic [2:0]         buf_hero_q, buf_hero_d;
`endif

    // Masked fly falls through to the other key compares and so yields code 0.
    always_comb begin
        press = keypad_pressed & ~kp_q;
        code  = 2'd0;
        if (key == KEY_VOLAR && HERO_FLY_MASK[heroe_seleccionado]) begin
            code = 2'd1;
        end else if (key == KEY_SALTAR) begin
            code = 2'd2;
        end else if (key == KEY_AGACHAR) begin
            code = 2'd3;
        end
        valid = press && (code != 2'd0);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mov_d       = mov_q;
        heroe_act_d = heroe_act_q;
        accepted_d  = 1'b0;
        done        = 1'b0;
`ifdef MOV_BUFFER_EN
        buf_full_d  = buf_full_q;
        buf_code_d  = buf_code_q;
        buf_hero_d  = buf_hero_q;
`endif
        if (presente != STATE_JUEGO) begin
            state_d = StIdle;
            cnt_d   = '0;
            mov_d   = 2'd0;
`ifdef MOV_BUFFER_EN
            buf_full_d = 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (valid) begin
                        state_d     = StAction;
                        cnt_d       = CNT_W'(ACT_CYCLES - 1);
                        mov_d       = code;
                        heroe_act_d = heroe_seleccionado;
                        accepted_d  = 1'b1;
                    end
                end
                StAction: begin
                    if (cnt_q == '0) begin
                        mov_d = 2'd0;
                        if (COOLDOWN_CYCLES == 0) begin
                            done = 1'b1;
                        end else begin
                            state_d = StCooldown;
                            cnt_d   = CNT_W'(COOLDOWN_CYCLES - 1);
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StCooldown: begin
                    if (cnt_q == '0) begin
                        done = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    mov_d   = 2'd0;
                end
            endcase
`ifdef MOV_BUFFER_EN
            if (state_q != StIdle && valid) begin
                buf_full_d = 1'b1;
                buf_code_d = code;
                buf_hero_d = heroe_seleccionado;
            end
`endif
            if (done) begin
                state_d = StIdle;
                cnt_d   = '0;
`ifdef MOV_BUFFER_EN
                // Chain straight into the buffered action instead of resting in idle.
                if (buf_full_d) begin
                    state_d     = StAction;
                    cnt_d       = CNT_W'(ACT_CYCLES - 1);
                    mov_d       = buf_code_d;
                    heroe_act_d = buf_hero_d;
                    accepted_d  = 1'b1;
                    buf_full_d  = 1'b0;
                end
`endif
            end
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mov_q       <= 2'd0;
            busy_q      <= 1'b0;
            accepted_q  <= 1'b0;
            heroe_act_q <= 3'd0;
            kp_q        <= 1'b0;
`ifdef MOV_BUFFER_EN
            buf_full_q  <= 1'b0;
            buf_code_q  <= 2'd0;
            buf_hero_q  <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mov_q       <= mov_d;
            busy_q      <= busy_d;
            accepted_q  <= accepted_d;
            heroe_act_q <= heroe_act_d;
            kp_q        <= keypad_pressed;
`ifdef MOV_BUFFER_EN
            buf_full_q  <= buf_full_d;
            buf_code_q  <= buf_code_d;
            buf_hero_q  <= buf_hero_d;
`endif
        end
    end

    assign mov       = mov_q;
    assign busy      = busy_q;
    assign accepted  = accepted_q;
    assign heroe_act = heroe_act_q;

endmodule

// File: tb/tb_hero_mov_ctrl.sv
// Bench for hero_mov_ctrl: vector table, hand sequences and random stimulus vs a timeline model.
module tb_hero_mov_ctrl;

    localparam int ACT  = 4;
    localparam int COOL = 2;
    localparam logic [7:0] MASK = 8'b0000_0001;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] presente;
    logic       keypad_pressed;
    logic [4:0] key;
    logic [2:0] heroe_seleccionado;
    logic [1:0] mov;
    logic       busy;
    logic       accepted;
    logic [2:0] heroe_act;

    int n_cmp = 0;
    int n_bad = 0;

    hero_mov_ctrl #(
        .ACT_CYCLES     (ACT),
        .COOLDOWN_CYCLES(COOL),
        .HERO_FLY_MASK  (MASK)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .presente          (presente),
        .keypad_pressed    (keypad_pressed),
        .key               (key),
        .heroe_seleccionado(heroe_seleccionado),
        .mov               (mov),
        .busy              (busy),
        .accepted          (accepted),
        .heroe_act         (heroe_act)
    );

    always #5 clk = ~clk;

    // Timeline model: an action accepted at edge a shows its code for edges a..a+ACT-1
    // and keeps busy until edge a+ACT+COOL, where the hero becomes free again.
    int   e;
    int   a;
    bit   m_active;
    int   m_code;
    bit   prev_kp;
    bit   b_full;
    int   b_code;
    int   b_hero;
    int   exp_mov, exp_busy, exp_acc, exp_hero;

    task automatic model_reset();
        e = 0; a = 0; m_active = 0; m_code = 0; prev_kp = 0;
        b_full = 0; b_code = 0; b_hero = 0;
        exp_mov = 0; exp_busy = 0; exp_acc = 0; exp_hero = 0;
    endtask

    function automatic int key_code(int k, int h);
        if (k == 6) return 2;
        if (k == 8) return 3;
        if (k == 2 && MASK[h] == 1'b1) return 1;
        return 0;
    endfunction

    task automatic model_edge();
        bit press;
        int c;
        e++;
        press = keypad_pressed && !prev_kp;
        prev_kp = keypad_pressed;
        c = press ? key_code(int'(key), int'(heroe_seleccionado)) : 0;
        exp_acc = 0;
        if (presente != 4'd3) begin
            m_active = 0;
            b_full = 0;
        end else if (!m_active || (e - 1 >= a + ACT + COOL)) begin
            m_active = 0;
            if (c != 0) begin
                a = e; m_active = 1; m_code = c; exp_hero = heroe_seleccionado; exp_acc = 1;
            end
        end else begin
`ifdef MOV_BUFFER_EN
            if (c != 0) begin
                b_full = 1; b_code = c; b_hero = heroe_seleccionado;
            end
`endif
            if (e == a + ACT + COOL) begin
                m_active = 0;
                if (b_full) begin
                    a = e; m_active = 1; m_code = b_code; exp_hero = b_hero; exp_acc = 1;
                    b_full = 0;
                end
            end
        end
        exp_mov  = (m_active && (e - a < ACT)) ? m_code : 0;
        exp_busy = (m_active && (e - a < ACT + COOL)) ? 1 : 0;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic drive(input int p, input int kp, input int k, input int h);
        presente           = 4'(p);
        keypad_pressed     = kp[0];
        key                = 5'(k);
        heroe_seleccionado = 3'(h);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_mov", int'(mov), exp_mov);
        chk("model_busy", int'(busy), exp_busy);
        chk("model_accepted", int'(accepted), exp_acc);
        chk("model_heroe_act", int'(heroe_act), exp_hero);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin
            drive(3, 0, 0, 0);
            step();
        end
    endtask

    typedef struct {
        int p, kp, k, h;
        int mv, bz, ac, ha;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl[NV];

    int acc_cnt, mov_cnt, c;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0);
        model_reset();
        #1;
        chk("reset_mov", int'(mov), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_accepted", int'(accepted), 0);
        chk("reset_heroe_act", int'(heroe_act), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        model_reset();

        // Jump, rejected fly for hero 1, accepted fly for hero 0.
        tbl[0]  = '{3, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{3, 1, 6, 0, 2, 1, 1, 0};
        tbl[2]  = '{3, 0, 6, 0, 2, 1, 0, 0};
        tbl[3]  = '{3, 0, 0, 0, 2, 1, 0, 0};
        tbl[4]  = '{3, 0, 0, 0, 2, 1, 0, 0};
        tbl[5]  = '{3, 0, 0, 0, 0, 1, 0, 0};
        tbl[6]  = '{3, 0, 0, 0, 0, 1, 0, 0};
        tbl[7]  = '{3, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{3, 1, 2, 1, 0, 0, 0, 0};
        tbl[9]  = '{3, 0, 2, 1, 0, 0, 0, 0};
        tbl[10] = '{3, 1, 2, 0, 1, 1, 1, 0};
        tbl[11] = '{3, 0, 0, 0, 1, 1, 0, 0};
        tbl[12] = '{3, 0, 0, 0, 1, 1, 0, 0};
        tbl[13] = '{3, 0, 0, 0, 1, 1, 0, 0};
        tbl[14] = '{3, 0, 0, 0, 0, 1, 0, 0};
        tbl[15] = '{3, 0, 0, 0, 0, 1, 0, 0};
        tbl[16] = '{3, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].p, tbl[i].kp, tbl[i].k, tbl[i].h);
            step();
            chk($sformatf("tbl%0d_mov", i), int'(mov), tbl[i].mv);
            chk($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].bz);
            chk($sformatf("tbl%0d_accepted", i), int'(accepted), tbl[i].ac);
            chk($sformatf("tbl%0d_heroe_act", i), int'(heroe_act), tbl[i].ha);
        end

        // Held key triggers exactly one crouch.
        acc_cnt = 0; mov_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive(3, 1, 8, 0);
            step();
            acc_cnt += int'(accepted);
            if (mov == 2'd3) mov_cnt++;
        end
        chk("hold_accepted_pulses", acc_cnt, 1);
        chk("hold_mov_cycles", mov_cnt, ACT);
        idle_steps(3);

        // Leaving the game state aborts the action; presses outside the game are ignored.
        drive(3, 1, 6, 0); step();
        chk("exit_start_mov", int'(mov), 2);
        drive(3, 0, 0, 0); step();
        drive(1, 0, 0, 0); step();
        chk("exit_mov", int'(mov), 0);
        chk("exit_busy", int'(busy), 0);
        drive(1, 1, 6, 0); step();
        chk("exit_press_accepted", int'(accepted), 0);
        chk("exit_press_mov", int'(mov), 0);
        idle_steps(2);

        // Asynchronous reset mid-action, then a normal press.
        drive(3, 1, 8, 0); step();
        drive(3, 0, 0, 0); step();
        #3 rst = 1'b1;
        #1;
        chk("async_rst_mov", int'(mov), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        drive(3, 1, 6, 0); step();
        chk("post_rst_accepted", int'(accepted), 1);
        chk("post_rst_mov", int'(mov), 2);
        idle_steps(ACT + COOL + 1);

        // Press during an action: chained with the buffer, dropped without it.
        drive(3, 1, 6, 0); step();
        drive(3, 0, 0, 0); step();
        drive(3, 1, 8, 0); step();
        for (int i = 3; i < ACT + COOL; i++) begin
            drive(3, 0, 0, 0); step();
        end
        drive(3, 0, 0, 0); step();
`ifdef MOV_BUFFER_EN
        chk("buffer_chain_mov", int'(mov), 3);
        chk("buffer_chain_accepted", int'(accepted), 1);
`else
        chk("nobuffer_mov", int'(mov), 0);
        chk("nobuffer_accepted", int'(accepted), 0);
`endif
        idle_steps(ACT + COOL + 2);

        // Random stimulus against the timeline model.
        for (int i = 0; i < 3000; i++) begin
            c = int'($urandom_range(0, 3));
            drive(($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 15)) : 3,
                  int'($urandom_range(0, 1)),
                  (c == 0) ? 2 : (c == 1) ? 6 : (c == 2) ? 8 : int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 7)));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
